// File: rtl/mmio_write_fifo_if.sv
// rtl/mmio_write_fifo_if.sv - CPU snoop bus, status read-back and consumer stream of the MMIO write FIFO
interface mmio_write_fifo_if #(
  parameter int WIDTH = 8,
  parameter int DEPTH = 8
);
  logic                       memwrite;
  logic                       memread;
  logic [WIDTH-1:0]           adr;
  logic [WIDTH-1:0]           writedata;
  logic [WIDTH-1:0]           io_rdata;
  logic                       io_hit;
  logic                       out_valid;
  logic [WIDTH-1:0]           out_data;
  logic                       out_ready;
  logic [$clog2(DEPTH):0]     count;
  logic                       overflow;

  modport master (
    output memwrite, memread, adr, writedata, out_ready,
    input  io_rdata, io_hit, out_valid, out_data, count, overflow
  );

  modport slave (
    input  memwrite, memread, adr, writedata, out_ready,
    output io_rdata, io_hit, out_valid, out_data, count, overflow
  );
endinterface

// File: rtl/mmio_write_fifo.sv
// rtl/mmio_write_fifo.sv - captures CPU writes to IO_ADDR into a show-ahead FIFO with a sticky overflow status
module mmio_write_fifo #(
  parameter int               WIDTH       = 8,
  parameter int               DEPTH       = 8,
  parameter logic [WIDTH-1:0] IO_ADDR     = 8'hFF,
  parameter logic [WIDTH-1:0] STATUS_ADDR = 8'hFE
) (
  input  logic            clk,
  input  logic            reset,
  mmio_write_fifo_if.slave bus
);
  localparam int AW = $clog2(DEPTH);
  localparam int CW = AW + 1;

  logic [WIDTH-1:0] mem [DEPTH];
  logic [AW-1:0]    wr_ptr_q, wr_ptr_d;
  logic [AW-1:0]    rd_ptr_q, rd_ptr_d;
  logic [CW-1:0]    count_q, count_d;
  logic             overflow_q, overflow_d;

  logic push_req, pop, full, empty, push_ok, drop, clear;
  logic [WIDTH-1:0] status;

  assign full     = (count_q == CW'(DEPTH));
  assign empty    = (count_q == '0);
  assign push_req = bus.memwrite && (bus.adr == IO_ADDR);
  assign pop      = !empty && bus.out_ready;
  // A pop in the same cycle frees a slot, so a full FIFO can still accept
  assign push_ok  = push_req && (!full || pop);
  assign drop     = push_req && full && !pop;
  assign clear    = bus.memwrite && (bus.adr == STATUS_ADDR) && bus.writedata[0];

  always_comb begin
    wr_ptr_d   = wr_ptr_q;
    rd_ptr_d   = rd_ptr_q;
    count_d    = count_q;
    overflow_d = overflow_q;
    if (push_ok) wr_ptr_d = wr_ptr_q + 1'b1;
    if (pop)     rd_ptr_d = rd_ptr_q + 1'b1;
    if (push_ok && !pop)      count_d = count_q + 1'b1;
    else if (!push_ok && pop) count_d = count_q - 1'b1;
    if (drop)       overflow_d = 1'b1;
    else if (clear) overflow_d = 1'b0;
  end

  always_ff @(posedge clk) begin
    if (!reset) begin
      wr_ptr_q   <= '0;
      rd_ptr_q   <= '0;
      count_q    <= '0;
      overflow_q <= 1'b0;
    end else begin
      wr_ptr_q   <= wr_ptr_d;
      rd_ptr_q   <= rd_ptr_d;
      count_q    <= count_d;
      overflow_q <= overflow_d;
    end
  end

  always_ff @(posedge clk) begin
    if (reset && push_ok) mem[wr_ptr_q] <= bus.writedata;
  end

  always_comb begin
    status             = '0;
    status[WIDTH-1]    = overflow_q;
    status[WIDTH-2]    = full;
    status[WIDTH-3]    = empty;
    status[CW-1:0]     = count_q;
  end

  assign bus.io_hit    = bus.memread && (bus.adr == STATUS_ADDR);
  assign bus.io_rdata  = bus.io_hit ? status : '0;
  assign bus.out_valid = !empty;
  assign bus.out_data  = empty ? '0 : mem[rd_ptr_q];
  assign bus.count     = count_q;
  assign bus.overflow  = overflow_q;
endmodule

// File: tb/tb_mmio_write_fifo.sv
// tb/tb_mmio_write_fifo.sv - directed and randomized bench for mmio_write_fifo against a queue model
module tb_mmio_write_fifo;
  logic clk = 1'b0;
  logic reset;
  always #5 clk = ~clk;

  mmio_write_fifo_if #(.WIDTH(8), .DEPTH(8)) bus ();

  mmio_write_fifo #(
    .WIDTH(8), .DEPTH(8), .IO_ADDR(8'hFF), .STATUS_ADDR(8'hFE)
  ) dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus)
  );

  bit [7:0] q[$];
  bit       m_ovf;
  int       total  = 0;
  int       passed = 0;

  task automatic drive(input logic mw, input logic mr, input logic [7:0] a,
                       input logic [7:0] wd, input logic rdy);
    bus.memwrite  = mw;
    bus.memread   = mr;
    bus.adr       = a;
    bus.writedata = wd;
    bus.out_ready = rdy;
  endtask

  // Advance one clock, updating the queue model from the inputs presented for that edge
  task automatic step();
    bit push, pop, clr, drop;
    if (!reset) begin
      q.delete();
      m_ovf = 1'b0;
    end else begin
      pop  = (q.size() != 0) && bus.out_ready;
      push = bus.memwrite && (bus.adr == 8'hFF);
      clr  = bus.memwrite && (bus.adr == 8'hFE) && bus.writedata[0];
      if (pop) void'(q.pop_front());
      drop = push && (q.size() == 8);
      if (push && !drop) q.push_back(bus.writedata);
      if (drop) m_ovf = 1'b1;
      else if (clr) m_ovf = 1'b0;
    end
    @(posedge clk);
    #1;
  endtask

  task automatic test_reset();
    reset = 1'b0;
    drive(1, 0, 8'hFF, 8'h33, 0);
    step();
    step();
    drive(0, 0, 8'h00, 8'h00, 0);
    #1;
    total++; if (bus.count !== 4'd0) $display("FAIL reset_count got=%0d exp=0", bus.count); else passed++;
    total++; if (bus.out_valid !== 1'b0) $display("FAIL reset_valid got=%b exp=0", bus.out_valid); else passed++;
    total++; if (bus.out_data !== 8'h00) $display("FAIL reset_data got=%h exp=00", bus.out_data); else passed++;
    total++; if (bus.overflow !== 1'b0) $display("FAIL reset_ovf got=%b exp=0", bus.overflow); else passed++;
    total++; if (bus.io_rdata !== 8'h00) $display("FAIL reset_rdata got=%h exp=00", bus.io_rdata); else passed++;
    reset = 1'b1;
  endtask

  task automatic test_capture();
    drive(1, 0, 8'hFF, 8'h0D, 0);
    step();
    drive(0, 0, 8'h00, 8'h00, 0);
    #1;
    total++; if (bus.out_valid !== 1'b1) $display("FAIL cap_valid got=%b exp=1", bus.out_valid); else passed++;
    total++; if (bus.out_data !== 8'h0D) $display("FAIL cap_data got=%h exp=0d", bus.out_data); else passed++;
    total++; if (bus.count !== 4'd1) $display("FAIL cap_count got=%0d exp=1", bus.count); else passed++;
    drive(0, 0, 8'h00, 8'h00, 1);
    step();
    total++; if (bus.out_valid !== 1'b0) $display("FAIL pop_valid got=%b exp=0", bus.out_valid); else passed++;
    total++; if (bus.count !== 4'd0) $display("FAIL pop_count got=%0d exp=0", bus.count); else passed++;
  endtask

  task automatic test_addr_filter();
    drive(1, 0, 8'h40, 8'h55, 0);
    step();
    total++; if (bus.count !== 4'd0) $display("FAIL filt_count got=%0d exp=0", bus.count); else passed++;
    drive(0, 1, 8'hFF, 8'h00, 0);
    #1;
    total++; if (bus.io_hit !== 1'b0) $display("FAIL filt_hit got=%b exp=0", bus.io_hit); else passed++;
    total++; if (bus.io_rdata !== 8'h00) $display("FAIL filt_rdata got=%h exp=00", bus.io_rdata); else passed++;
    drive(0, 1, 8'hFE, 8'h00, 0);
    #1;
    total++; if (bus.io_rdata !== 8'h20) $display("FAIL empty_status got=%h exp=20", bus.io_rdata); else passed++;
  endtask

  task automatic test_overflow();
    for (int i = 1; i <= 9; i++) begin
      drive(1, 0, 8'hFF, 8'(i), 0);
      step();
    end
    drive(0, 0, 8'h00, 8'h00, 0);
    #1;
    total++; if (bus.count !== 4'd8) $display("FAIL ovf_count got=%0d exp=8", bus.count); else passed++;
    total++; if (bus.overflow !== 1'b1) $display("FAIL ovf_flag got=%b exp=1", bus.overflow); else passed++;
    drive(0, 1, 8'hFE, 8'h00, 0);
    #1;
    total++; if (bus.io_hit !== 1'b1) $display("FAIL ovf_hit got=%b exp=1", bus.io_hit); else passed++;
    total++; if (bus.io_rdata !== 8'hC8) $display("FAIL ovf_status got=%h exp=c8", bus.io_rdata); else passed++;
    for (int i = 1; i <= 8; i++) begin
      drive(0, 0, 8'h00, 8'h00, 1);
      #1;
      total++; if (bus.out_data !== 8'(i)) $display("FAIL ovf_drain[%0d] got=%h exp=%h", i, bus.out_data, 8'(i)); else passed++;
      step();
    end
    total++; if (bus.out_valid !== 1'b0) $display("FAIL ovf_drained got=%b exp=0", bus.out_valid); else passed++;
    total++; if (bus.overflow !== 1'b1) $display("FAIL ovf_sticky got=%b exp=1", bus.overflow); else passed++;
  endtask

  task automatic test_full_push_pop();
    bit [7:0] exp_order[8] = '{8'h02, 8'h03, 8'h04, 8'h05, 8'h06, 8'h07, 8'h08, 8'hAA};
    drive(1, 0, 8'hFE, 8'h01, 0);
    step();
    total++; if (bus.overflow !== 1'b0) $display("FAIL fpp_clear got=%b exp=0", bus.overflow); else passed++;
    for (int i = 1; i <= 8; i++) begin
      drive(1, 0, 8'hFF, 8'(i), 0);
      step();
    end
    drive(1, 0, 8'hFF, 8'hAA, 1);
    step();
    drive(0, 0, 8'h00, 8'h00, 0);
    #1;
    total++; if (bus.count !== 4'd8) $display("FAIL fpp_count got=%0d exp=8", bus.count); else passed++;
    total++; if (bus.overflow !== 1'b0) $display("FAIL fpp_ovf got=%b exp=0", bus.overflow); else passed++;
    for (int i = 0; i < 8; i++) begin
      drive(0, 0, 8'h00, 8'h00, 1);
      #1;
      total++; if (bus.out_data !== exp_order[i]) $display("FAIL fpp_drain[%0d] got=%h exp=%h", i, bus.out_data, exp_order[i]); else passed++;
      step();
    end
    total++; if (bus.count !== 4'd0) $display("FAIL fpp_empty got=%0d exp=0", bus.count); else passed++;
  endtask

  task automatic test_clear_reset();
    for (int i = 0; i < 9; i++) begin
      drive(1, 0, 8'hFF, 8'(8'h30 + i), 0);
      step();
    end
    total++; if (bus.overflow !== 1'b1) $display("FAIL clr_pre got=%b exp=1", bus.overflow); else passed++;
    drive(1, 0, 8'hFE, 8'h01, 0);
    step();
    total++; if (bus.overflow !== 1'b0) $display("FAIL clr_flag got=%b exp=0", bus.overflow); else passed++;
    drive(0, 1, 8'hFE, 8'h00, 0);
    #1;
    total++; if (bus.io_rdata[7] !== 1'b0) $display("FAIL clr_bit7 got=%b exp=0", bus.io_rdata[7]); else passed++;
    drive(1, 0, 8'hFF, 8'h77, 0);
    step();
    drive(1, 0, 8'hFE, 8'h00, 0);
    step();
    total++; if (bus.overflow !== 1'b1) $display("FAIL noclr_flag got=%b exp=1", bus.overflow); else passed++;
    for (int i = 0; i < 3; i++) begin
      drive(0, 0, 8'h00, 8'h00, 1);
      step();
    end
    total++; if (bus.count !== 4'd5) $display("FAIL mid_count got=%0d exp=5", bus.count); else passed++;
    reset = 1'b0;
    drive(1, 0, 8'hFF, 8'h99, 1);
    step();
    reset = 1'b1;
    drive(0, 0, 8'h00, 8'h00, 0);
    #1;
    total++; if (bus.count !== 4'd0) $display("FAIL mid_reset_count got=%0d exp=0", bus.count); else passed++;
    total++; if (bus.out_valid !== 1'b0) $display("FAIL mid_reset_valid got=%b exp=0", bus.out_valid); else passed++;
    total++; if (bus.overflow !== 1'b0) $display("FAIL mid_reset_ovf got=%b exp=0", bus.overflow); else passed++;
  endtask

  task automatic test_random();
    logic [7:0] a, exp_st, exp_head;
    logic       rdy, mr;
    for (int n = 0; n < 600; n++) begin
      case ($urandom_range(0, 3))
        0, 1:    a = 8'hFF;
        2:       a = 8'hFE;
        default: a = 8'($urandom);
      endcase
      rdy   = (n < 300) ? ($urandom_range(0, 3) == 0) : ($urandom_range(0, 1) == 1);
      mr    = ($urandom_range(0, 1) == 1);
      reset = ($urandom_range(0, 79) != 0);
      drive(logic'($urandom_range(0, 1)), mr, a, 8'($urandom), rdy);
      #1;
      exp_st = 8'(q.size()) | (q.size() == 0 ? 8'h20 : 8'h00) | (q.size() == 8 ? 8'h40 : 8'h00)
               | (m_ovf ? 8'h80 : 8'h00);
      if (!(mr && a == 8'hFE)) exp_st = 8'h00;
      total++; if (bus.io_rdata !== exp_st) $display("FAIL rnd_status[%0d] got=%h exp=%h", n, bus.io_rdata, exp_st); else passed++;
      step();
      exp_head = (q.size() != 0) ? q[0] : 8'h00;
      total++; if (bus.count !== 4'(q.size())) $display("FAIL rnd_count[%0d] got=%0d exp=%0d", n, bus.count, q.size()); else passed++;
      total++; if (bus.out_data !== exp_head) $display("FAIL rnd_head[%0d] got=%h exp=%h", n, bus.out_data, exp_head); else passed++;
      total++; if (bus.out_valid !== (q.size() != 0)) $display("FAIL rnd_valid[%0d] got=%b exp=%b", n, bus.out_valid, q.size() != 0); else passed++;
      total++; if (bus.overflow !== m_ovf) $display("FAIL rnd_ovf[%0d] got=%b exp=%b", n, bus.overflow, m_ovf); else passed++;
    end
    reset = 1'b1;
  endtask

  initial begin
    reset = 1'b0;
    drive(0, 0, 8'h00, 8'h00, 0);
    test_reset();
    test_capture();
    test_addr_filter();
    test_overflow();
    test_full_push_pop();
    test_clear_reset();
    test_random();
    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end
endmodule
